// File: rtl/gb_mem_pkg.sv
// Shared memory-map constants, PPU mode and OAM DMA state types for the
// VRAM/OAM arbitration slice.
package gb_mem_pkg;

  localparam logic [15:0] VRAM_BASE    = 16'h8000;
  localparam logic [15:0] VRAM_END     = 16'h9FFF;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam logic [15:0] OAM_END      = 16'hFE9F;
  localparam logic [15:0] UNUSABLE_END = 16'hFEFF;
  localparam logic [15:0] DMA_REG      = 16'hFF46;
  localparam logic [7:0]  OPEN_BUS     = 8'hFF;

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'd0,
    MODE_VBLANK = 2'd1,
    MODE_SCAN   = 2'd2,
    MODE_DRAW   = 2'd3
  } ppu_mode_t;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_START,
    DMA_READ,
    DMA_WAIT,
    DMA_WRITE
  } dma_state_t;

  typedef enum logic {
    TGT_VRAM,
    TGT_OAM
  } tgt_t;

  // One in-flight read: whether it exists, which macro it targets, and
  // whether the port was actually granted.
  typedef struct packed {
    logic pend;
    tgt_t tgt;
    logic gnt;
  } rd_tag_t;

  function automatic logic in_vram(input logic [15:0] a);
    return (a >= VRAM_BASE) && (a <= VRAM_END);
  endfunction

  function automatic logic in_oam(input logic [15:0] a);
    return (a >= OAM_BASE) && (a <= OAM_END);
  endfunction

  function automatic logic in_unusable(input logic [15:0] a);
    return (a > OAM_END) && (a <= UNUSABLE_END);
  endfunction

  // E0-FF sources alias work RAM through the echo region.
  function automatic logic [7:0] dma_eff_hi(input logic [7:0] v);
    return (v >= 8'hE0) ? (v - 8'h20) : v;
  endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: start delay, source read, latency wait and OAM write per
// byte, restartable at any time by a new trigger.
module oam_dma_engine
  import gb_mem_pkg::*;
#(
  parameter int unsigned SRC_LAT       = 1,
  parameter int unsigned DMA_START_DLY = 1,
  parameter int unsigned OAM_BYTES     = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  start_hi,
  input  logic [7:0]  src_rdata,
  output logic        active,
  output logic        src_rd,
  output logic [15:0] src_addr,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata
);

  localparam logic [7:0] LAST_IDX  = 8'(OAM_BYTES - 1);
  localparam logic [7:0] START_CNT = 8'(DMA_START_DLY - 1);
  localparam logic [7:0] WAIT_CNT  = 8'(SRC_LAT - 2);

  dma_state_t state;
  logic [7:0] idx;
  logic [7:0] hi;
  logic [7:0] cnt;

  assign src_addr  = {hi, idx};
  assign oam_addr  = idx;
  // Source data lands in the WRITE cycle and is forwarded straight to OAM.
  assign oam_wdata = src_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= DMA_IDLE;
      idx    <= '0;
      hi     <= '0;
      cnt    <= '0;
      active <= 1'b0;
      src_rd <= 1'b0;
      oam_we <= 1'b0;
    end else begin
      src_rd <= 1'b0;
      oam_we <= 1'b0;
      if (start) begin
        hi     <= start_hi;
        idx    <= '0;
        active <= 1'b1;
        if (DMA_START_DLY == 0) begin
          state  <= DMA_READ;
          src_rd <= 1'b1;
        end else begin
          state <= DMA_START;
          cnt   <= START_CNT;
        end
      end else begin
        case (state)
          DMA_IDLE: begin
            active <= 1'b0;
          end
          DMA_START: begin
            if (cnt == '0) begin
              state  <= DMA_READ;
              src_rd <= 1'b1;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          DMA_READ: begin
            if (SRC_LAT <= 1) begin
              state  <= DMA_WRITE;
              oam_we <= 1'b1;
            end else begin
              state <= DMA_WAIT;
              cnt   <= WAIT_CNT;
            end
          end
          DMA_WAIT: begin
            if (cnt == '0) begin
              state  <= DMA_WRITE;
              oam_we <= 1'b1;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          DMA_WRITE: begin
            if (idx == LAST_IDX) begin
              state  <= DMA_IDLE;
              idx    <= '0;
              active <= 1'b0;
            end else begin
              state  <= DMA_READ;
              idx    <= idx + 8'd1;
              src_rd <= 1'b1;
            end
          end
          default: begin
            state  <= DMA_IDLE;
            active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/vram_oam_arbiter.sv
// Arbitrates the single-port VRAM and OAM macros between CPU, PPU and OAM
// DMA, with mode-based CPU locking and a one-cycle read return path.
module vram_oam_arbiter
  import gb_mem_pkg::*;
#(
  parameter int unsigned SRC_LAT       = 1,
  parameter int unsigned DMA_START_DLY = 1,
  parameter int unsigned OAM_BYTES     = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lcd_on,
  input  logic [1:0]  ppu_mode,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic        ppu_rd,
  input  logic [15:0] ppu_addr,
  output logic [7:0]  ppu_rdata,
  output logic [15:0] dma_src_addr,
  output logic        dma_src_rd,
  input  logic [7:0]  dma_src_rdata,
  output logic [12:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  output logic [7:0]  oam_addr,
  output logic        oam_we,
  output logic [7:0]  oam_wdata,
  input  logic [7:0]  oam_rdata,
  output logic        dma_active,
  output logic [7:0]  dma_src_hi
);

  ppu_mode_t mode;
  logic       dma_start;
  logic [7:0] dma_start_hi;
  logic       dma_we;
  logic [7:0] dma_oam_addr;
  logic [7:0] dma_oam_wdata;

  assign mode         = ppu_mode_t'(ppu_mode);
  assign dma_start    = cpu_wr && (cpu_addr == DMA_REG);
  assign dma_start_hi = dma_eff_hi(cpu_wdata);

  oam_dma_engine #(
    .SRC_LAT       (SRC_LAT),
    .DMA_START_DLY (DMA_START_DLY),
    .OAM_BYTES     (OAM_BYTES)
  ) u_dma (
    .clk       (clk),
    .rst       (rst),
    .start     (dma_start),
    .start_hi  (dma_start_hi),
    .src_rdata (dma_src_rdata),
    .active    (dma_active),
    .src_rd    (dma_src_rd),
    .src_addr  (dma_src_addr),
    .oam_we    (dma_we),
    .oam_addr  (dma_oam_addr),
    .oam_wdata (dma_oam_wdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dma_src_hi <= '0;
    end else if (dma_start) begin
      dma_src_hi <= cpu_wdata;
    end
  end

  logic cpu_req;
  logic ppu_vram_req;
  logic ppu_oam_req;
  logic cpu_vram_ok;
  logic cpu_oam_ok;
  logic cpu_gnt_vram;
  logic cpu_gnt_oam;
  logic ppu_gnt;

  assign cpu_req      = cpu_rd || cpu_wr;
  assign ppu_vram_req = ppu_rd && in_vram(ppu_addr);
  assign ppu_oam_req  = ppu_rd && in_oam(ppu_addr);
  assign cpu_vram_ok  = !lcd_on || (mode != MODE_DRAW);
  // dma_active is registered, so an FF46 write in this same cycle does not
  // yet lock out an OAM access presented alongside it.
  assign cpu_oam_ok   = !dma_active &&
                        (!lcd_on || (mode == MODE_HBLANK) || (mode == MODE_VBLANK));

  always_comb begin
    vram_addr    = '0;
    vram_we      = 1'b0;
    vram_wdata   = '0;
    oam_addr     = '0;
    oam_we       = 1'b0;
    oam_wdata    = '0;
    cpu_gnt_vram = 1'b0;
    cpu_gnt_oam  = 1'b0;
    ppu_gnt      = 1'b0;
    if (rst) begin
      if (ppu_vram_req) begin
        vram_addr = ppu_addr[12:0];
        ppu_gnt   = 1'b1;
      end else if (cpu_req && in_vram(cpu_addr) && cpu_vram_ok) begin
        vram_addr    = cpu_addr[12:0];
        vram_we      = cpu_wr;
        vram_wdata   = cpu_wdata;
        cpu_gnt_vram = 1'b1;
      end

      if (dma_we) begin
        oam_addr  = dma_oam_addr;
        oam_we    = 1'b1;
        oam_wdata = dma_oam_wdata;
      end else if (ppu_oam_req) begin
        if (!dma_active) begin
          oam_addr = ppu_addr[7:0];
          ppu_gnt  = 1'b1;
        end
      end else if (cpu_req && in_oam(cpu_addr) && cpu_oam_ok) begin
        oam_addr    = cpu_addr[7:0];
        oam_we      = cpu_wr;
        oam_wdata   = cpu_wdata;
        cpu_gnt_oam = 1'b1;
      end
    end
  end

  rd_tag_t cpu_tag;
  rd_tag_t ppu_tag;
  rd_tag_t cpu_tag_next;
  rd_tag_t ppu_tag_next;
  logic [7:0] cpu_hold;
  logic [7:0] ppu_hold;

  always_comb begin
    cpu_tag_next.pend = cpu_rd &&
                        (in_vram(cpu_addr) || in_oam(cpu_addr) || in_unusable(cpu_addr));
    cpu_tag_next.tgt  = in_oam(cpu_addr) ? TGT_OAM : TGT_VRAM;
    cpu_tag_next.gnt  = cpu_gnt_vram || cpu_gnt_oam;
    ppu_tag_next.pend = ppu_rd;
    ppu_tag_next.tgt  = in_oam(ppu_addr) ? TGT_OAM : TGT_VRAM;
    ppu_tag_next.gnt  = ppu_gnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_tag  <= '0;
      ppu_tag  <= '0;
      cpu_hold <= OPEN_BUS;
      ppu_hold <= OPEN_BUS;
    end else begin
      cpu_tag  <= cpu_tag_next;
      ppu_tag  <= ppu_tag_next;
      cpu_hold <= cpu_rdata;
      ppu_hold <= ppu_rdata;
    end
  end

  // Macro data is only valid in the return cycle; the hold registers keep
  // it visible afterwards.
  always_comb begin
    cpu_rdata = cpu_hold;
    if (cpu_tag.pend) begin
      if (!cpu_tag.gnt)                 cpu_rdata = OPEN_BUS;
      else if (cpu_tag.tgt == TGT_OAM)  cpu_rdata = oam_rdata;
      else                              cpu_rdata = vram_rdata;
    end
    ppu_rdata = ppu_hold;
    if (ppu_tag.pend) begin
      if (!ppu_tag.gnt)                 ppu_rdata = OPEN_BUS;
      else if (ppu_tag.tgt == TGT_OAM)  ppu_rdata = oam_rdata;
      else                              ppu_rdata = vram_rdata;
    end
  end

endmodule

// File: tb/tb_vram_oam_arbiter.sv
// Randomized bench for vram_oam_arbiter against a rule-level access model
// with behavioural VRAM, OAM and DMA-source memories.
module tb_vram_oam_arbiter;

  localparam int unsigned SRC_LAT       = 1;
  localparam int unsigned DMA_START_DLY = 1;
  localparam int unsigned OAM_BYTES     = 160;

  logic        clk = 1'b0;
  logic        rst;
  logic        lcd_on;
  logic [1:0]  ppu_mode;
  logic [15:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        ppu_rd;
  logic [15:0] ppu_addr;
  logic [7:0]  ppu_rdata;
  logic [15:0] dma_src_addr;
  logic        dma_src_rd;
  logic [7:0]  dma_src_rdata;
  logic [12:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;
  logic [7:0]  oam_addr;
  logic        oam_we;
  logic [7:0]  oam_wdata;
  logic [7:0]  oam_rdata;
  logic        dma_active;
  logic [7:0]  dma_src_hi;

  always #5 clk = ~clk;

  vram_oam_arbiter #(
    .SRC_LAT       (SRC_LAT),
    .DMA_START_DLY (DMA_START_DLY),
    .OAM_BYTES     (OAM_BYTES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .lcd_on        (lcd_on),
    .ppu_mode      (ppu_mode),
    .cpu_addr      (cpu_addr),
    .cpu_rd        (cpu_rd),
    .cpu_wr        (cpu_wr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .ppu_rd        (ppu_rd),
    .ppu_addr      (ppu_addr),
    .ppu_rdata     (ppu_rdata),
    .dma_src_addr  (dma_src_addr),
    .dma_src_rd    (dma_src_rd),
    .dma_src_rdata (dma_src_rdata),
    .vram_addr     (vram_addr),
    .vram_we       (vram_we),
    .vram_wdata    (vram_wdata),
    .vram_rdata    (vram_rdata),
    .oam_addr      (oam_addr),
    .oam_we        (oam_we),
    .oam_wdata     (oam_wdata),
    .oam_rdata     (oam_rdata),
    .dma_active    (dma_active),
    .dma_src_hi    (dma_src_hi)
  );

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] eff_of(input logic [7:0] v);
    return (v >= 8'd224) ? v - 8'd32 : v;
  endfunction

  // Behavioural macros: synchronous read, 1-cycle source latency.
  logic [7:0] vmem [8192];
  logic [7:0] omem [160];
  always @(posedge clk) begin
    if (vram_we) vmem[vram_addr] <= vram_wdata;
    vram_rdata <= vmem[vram_addr];
    if (oam_we && oam_addr < 8'd160) omem[oam_addr] <= oam_wdata;
    oam_rdata <= (oam_addr < 8'd160) ? omem[oam_addr] : 8'hFF;
    if (dma_src_rd) dma_src_rdata <= src_byte(dma_src_addr);
  end

  // Reference contents and expected held read data.
  logic [7:0] vref [8192];
  logic [7:0] oref [160];
  logic [7:0] exp_cpu_hold;
  logic [7:0] exp_ppu_hold;
  logic       dma_on;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_rd = 1'b0; cpu_wr = 1'b0; ppu_rd = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; ppu_addr = '0;
  endtask

  // One CPU/PPU access cycle followed by a return cycle, checked against the
  // lock/priority rules.
  task automatic access(input logic lcd, input logic [1:0] mode,
                        input logic crd, input logic cwr,
                        input logic [15:0] caddr, input logic [7:0] cwd,
                        input logic prd, input logic [15:0] paddr);
    logic c_vram, c_oam, p_vram, p_oam, cg_v, cg_o;
    logic [7:0] ecpu, eppu;
    c_vram = caddr >= 16'h8000 && caddr <= 16'h9FFF;
    c_oam  = caddr >= 16'hFE00 && caddr <= 16'hFE9F;
    p_vram = prd && paddr >= 16'h8000 && paddr <= 16'h9FFF;
    p_oam  = prd && paddr >= 16'hFE00 && paddr <= 16'hFE9F;
    cg_v = (crd || cwr) && c_vram && !p_vram && (!lcd || mode != 2'd3);
    cg_o = (crd || cwr) && c_oam && !p_oam && !dma_on && (!lcd || mode < 2'd2);
    ecpu = cg_v ? vref[caddr[12:0]] : cg_o ? oref[int'(caddr - 16'hFE00)] : 8'hFF;
    eppu = p_vram ? vref[paddr[12:0]] :
           (p_oam && !dma_on) ? oref[int'(paddr - 16'hFE00)] : 8'hFF;

    @(negedge clk);
    chk("cpu_hold", cpu_rdata, exp_cpu_hold);
    chk("ppu_hold", ppu_rdata, exp_ppu_hold);
    lcd_on = lcd; ppu_mode = mode;
    cpu_rd = crd; cpu_wr = cwr; cpu_addr = caddr; cpu_wdata = cwd;
    ppu_rd = prd; ppu_addr = paddr;
    #1;
    chk("vram_we", vram_we, cwr && cg_v);
    chk("oam_we", oam_we, cwr && cg_o);
    @(negedge clk);
    if (crd) begin
      chk("cpu_rdata", cpu_rdata, ecpu);
      exp_cpu_hold = ecpu;
    end
    if (prd) begin
      chk("ppu_rdata", ppu_rdata, eppu);
      exp_ppu_hold = eppu;
    end
    idle_inputs();
    if (cwr && cg_v) vref[caddr[12:0]] = cwd;
    if (cwr && cg_o) oref[int'(caddr - 16'hFE00)] = cwd;
  endtask

  function automatic logic [15:0] pick_vram();
    logic [5:0] o;
    o = 6'($urandom_range(0, 63));
    return ($urandom_range(0, 1) == 0) ? (16'h8000 + 16'(o)) : (16'h9800 + 16'(o));
  endfunction

  task automatic rand_access();
    int op, kind;
    logic [15:0] ca, pa;
    op   = $urandom_range(0, 3);
    kind = $urandom_range(0, 4);
    if (kind < 2)       ca = pick_vram();
    else if (kind < 4)  ca = 16'hFE00 + 16'($urandom_range(0, 159));
    else                ca = 16'hFEA0 + 16'($urandom_range(0, 95));
    pa = ($urandom_range(0, 1) == 0) ? pick_vram() : 16'hFE00 + 16'($urandom_range(0, 159));
    access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           op < 2, op == 2, ca, 8'($urandom), 1'($urandom_range(0, 1)), pa);
  endtask

  // Triggers a DMA from page hi; optionally restarts it with hi2 after
  // restart_at bytes, or resets the DUT after abort_at bytes.
  task automatic dma_run(input logic [7:0] hi, input int restart_at,
                         input logic [7:0] hi2, input int abort_at);
    logic [7:0] eff, exp_c, exp_p, exp_hi;
    int act, nwr, nrd, first_rd, bad;
    logic done, chk_c, chk_p, chk_hi, restarted;
    @(negedge clk);
    lcd_on = 1'b1; ppu_mode = 2'd1;
    cpu_addr = 16'hFF46; cpu_wdata = hi; cpu_wr = 1'b1;
    eff = eff_of(hi); exp_hi = hi; chk_hi = 1'b1; dma_on = 1'b1;
    act = 0; nwr = 0; nrd = 0; first_rd = -1;
    done = 1'b0; chk_c = 1'b0; chk_p = 1'b0; restarted = 1'b0;
    exp_c = 8'hFF; exp_p = 8'hFF;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      @(negedge clk);
      idle_inputs();
      if (chk_hi) begin chk("dma_src_hi", dma_src_hi, exp_hi); chk_hi = 1'b0; end
      if (chk_c) begin chk("dma_cpu_rdata", cpu_rdata, exp_c); exp_cpu_hold = exp_c; chk_c = 1'b0; end
      if (chk_p) begin chk("dma_ppu_rdata", ppu_rdata, exp_p); exp_ppu_hold = exp_p; chk_p = 1'b0; end
      if (!dma_active) begin
        done = 1'b1;
      end else begin
        act++;
        if (dma_src_rd) begin
          if (first_rd < 0) first_rd = act;
          chk("dma_src_addr", dma_src_addr, {eff, 8'(nrd)});
          nrd++;
        end
        if (oam_we) begin
          chk("dma_oam_addr", oam_addr, 32'(nwr));
          chk("dma_oam_wdata", oam_wdata, src_byte({eff, 8'(nwr)}));
          if (nwr < 160) oref[nwr] = src_byte({eff, 8'(nwr)});
          nwr++;
        end
        if (act == 10) begin
          cpu_rd = 1'b1; cpu_addr = 16'hFE00; ppu_rd = 1'b1; ppu_addr = 16'hFE10;
          exp_c = 8'hFF; exp_p = 8'hFF; chk_c = 1'b1; chk_p = 1'b1;
        end
        if (act == 20) begin
          lcd_on = 1'b1; ppu_mode = 2'd1; cpu_rd = 1'b1; cpu_addr = 16'h8000;
          exp_c = vref[0]; chk_c = 1'b1;
        end
        if (abort_at >= 0 && nwr == abort_at) begin
          rst = 1'b0;
          #1;
          chk("abort_dma_active", dma_active, 0);
          chk("abort_oam_we", oam_we, 0);
          chk("abort_vram_we", vram_we, 0);
          chk("abort_src_rd", dma_src_rd, 0);
          chk("abort_src_hi", dma_src_hi, 0);
          chk("abort_cpu_rdata", cpu_rdata, 8'hFF);
          chk("abort_ppu_rdata", ppu_rdata, 8'hFF);
          exp_cpu_hold = 8'hFF; exp_ppu_hold = 8'hFF;
          @(negedge clk);
          rst = 1'b1;
          bad = 0;
          for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (oam_we || dma_src_rd || dma_active) bad++;
          end
          chk("post_abort_activity", bad, 0);
          done = 1'b1;
        end else if (!restarted && restart_at >= 0 && nwr == restart_at) begin
          cpu_addr = 16'hFF46; cpu_wdata = hi2; cpu_wr = 1'b1;
          eff = eff_of(hi2); exp_hi = hi2; chk_hi = 1'b1; restarted = 1'b1;
          act = 0; nwr = 0; nrd = 0; first_rd = -1;
        end
      end
    end
    chk("dma_finished", done, 1);
    if (abort_at < 0) begin
      chk("dma_active_cycles", act, DMA_START_DLY + OAM_BYTES * (1 + SRC_LAT));
      chk("dma_write_count", nwr, OAM_BYTES);
      chk("dma_read_count", nrd, OAM_BYTES);
      chk("dma_first_read", first_rd, DMA_START_DLY + 1);
    end
    dma_on = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0; lcd_on = 1'b0; ppu_mode = 2'd0; dma_on = 1'b0;
    idle_inputs();
    exp_cpu_hold = 8'hFF; exp_ppu_hold = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_cpu_rdata", cpu_rdata, 8'hFF);
    chk("rst_ppu_rdata", ppu_rdata, 8'hFF);
    chk("rst_dma_active", dma_active, 0);
    chk("rst_dma_src_hi", dma_src_hi, 0);
    chk("rst_dma_src_rd", dma_src_rd, 0);
    chk("rst_vram_we", vram_we, 0);
    chk("rst_oam_we", oam_we, 0);
    rst = 1'b1;

    // Preload the VRAM windows and all of OAM with the display off.
    for (int i = 0; i < 64; i++) begin
      access(1'b0, 2'd3, 1'b0, 1'b1, 16'h8000 + 16'(i), 8'($urandom), 1'b0, 16'h0);
      access(1'b0, 2'd3, 1'b0, 1'b1, 16'h9800 + 16'(i), 8'($urandom), 1'b0, 16'h0);
    end
    for (int i = 0; i < 160; i++)
      access(1'b0, 2'd2, 1'b0, 1'b1, 16'hFE00 + 16'(i), 8'($urandom), 1'b0, 16'h0);

    // Locked VRAM write in DRAW, then read back in HBLANK.
    access(1'b1, 2'd3, 1'b0, 1'b1, 16'h8010, 8'h5A, 1'b0, 16'h0);
    access(1'b1, 2'd0, 1'b1, 1'b0, 16'h8010, 8'h00, 1'b0, 16'h0);
    // CPU OAM read alongside PPU VRAM read.
    access(1'b1, 2'd0, 1'b1, 1'b0, 16'hFE04, 8'h00, 1'b1, 16'h9800);
    // PPU beats CPU on VRAM; unusable region reads open bus.
    access(1'b1, 2'd0, 1'b1, 1'b0, 16'h8020, 8'h00, 1'b1, 16'h8021);
    access(1'b0, 2'd0, 1'b1, 1'b0, 16'hFEA0, 8'h00, 1'b0, 16'h0);
    access(1'b0, 2'd0, 1'b0, 1'b1, 16'hFEFF, 8'h77, 1'b0, 16'h0);

    for (int i = 0; i < 200; i++) rand_access();

    dma_run(8'hC1, -1, 8'h00, -1);
    for (int i = 0; i < 100; i++) rand_access();

    dma_run(8'hE2, 50, 8'hC3, -1);
    for (int i = 0; i < 100; i++) rand_access();

    dma_run(8'hD0, -1, 8'h00, 20);
    for (int i = 0; i < 100; i++) rand_access();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
